// File: rtl/segre_store_buffer.sv
// Coalescing store buffer: queues byte-enabled word stores toward memory and
// answers forwarding queries from loads against the resident entries.
module segre_store_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       st_valid_i,
    output logic                       st_ready_o,
    input  logic [ADDR_W-1:0]          st_addr_i,
    input  logic [DATA_W-1:0]          st_data_i,
    input  logic [1:0]                 st_type_i,
    input  logic                       ld_valid_i,
    input  logic [ADDR_W-1:0]          ld_addr_i,
    input  logic [1:0]                 ld_type_i,
    output logic                       ld_hit_o,
    output logic                       ld_stall_o,
    output logic [DATA_W-1:0]          ld_data_o,
    output logic                       mem_valid_o,
    input  logic                       mem_ready_i,
    output logic [ADDR_W-1:0]          mem_addr_o,
    output logic [DATA_W-1:0]          mem_data_o,
    output logic [DATA_W/8-1:0]        mem_be_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic                       err_o
);

    localparam int unsigned NB = DATA_W / 8;
    localparam int unsigned OW = $clog2(NB);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    localparam logic [1:0] TYPE_BYTE = 2'd0;
    localparam logic [1:0] TYPE_HALF = 2'd1;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [NB-1:0]     be_q   [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          err_q, err_d;

    function automatic logic [NB-1:0] lane_be(input logic [1:0] t, input logic [OW-1:0] off);
        case (t)
            TYPE_BYTE: lane_be = NB'(1) << off;
            TYPE_HALF: lane_be = NB'(3) << off;
            default:   lane_be = '1;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] t, input logic [OW-1:0] off);
        case (t)
            TYPE_BYTE: is_misaligned = 1'b0;
            TYPE_HALF: is_misaligned = off[0];
            default:   is_misaligned = (off != '0);
        endcase
    endfunction

    logic [OW-1:0]     st_off;
    logic [ADDR_W-1:0] st_waddr;
    logic [NB-1:0]     st_be;
    logic [DATA_W-1:0] st_data_sh;
    logic [DATA_W-1:0] merged;
    logic [PW-1:0]     young;
    logic              st_hs, st_mis, st_acc, st_coal, st_app, pop;

    assign st_off     = st_addr_i[OW-1:0];
    assign st_waddr   = {st_addr_i[ADDR_W-1:OW], OW'(0)};
    assign st_be      = lane_be(st_type_i, st_off);
    assign st_data_sh = st_data_i << {st_off, 3'b000};
    assign st_mis     = is_misaligned(st_type_i, st_off);
    assign young      = tail_q - PW'(1);

    assign st_hs   = st_valid_i && st_ready_o;
    assign st_acc  = st_hs && !st_mis;
    // Youngest is never the head once two entries are resident, so the head stays frozen.
    assign st_coal = st_acc && (count_q >= CW'(2)) && (addr_q[young] == st_waddr);
    assign st_app  = st_acc && !st_coal;
    assign pop     = mem_valid_o && mem_ready_i;

    always_comb begin
        merged = data_q[young];
        for (int b = 0; b < NB; b++) begin
            if (st_be[b]) merged[8*b +: 8] = st_data_sh[8*b +: 8];
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        err_d   = st_hs && st_mis;
        if (st_app) tail_d = tail_q + PW'(1);
        if (pop)    head_d = head_q + PW'(1);
        count_d = count_q + CW'(st_app) - CW'(pop);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Entry payload needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk_i) begin
        if (st_app) begin
            addr_q[tail_q] <= st_waddr;
            data_q[tail_q] <= st_data_sh;
            be_q[tail_q]   <= st_be;
        end else if (st_coal) begin
            data_q[young] <= merged;
            be_q[young]   <= be_q[young] | st_be;
        end
    end

    logic [NB-1:0]     ld_be;
    logic [ADDR_W-1:0] ld_waddr;
    logic [PW-1:0]     ld_idx;
    logic              ld_match, ld_cover;
    logic [NB-1:0]     m_be;
    logic [DATA_W-1:0] m_data;

    // Scan oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        ld_be    = lane_be(ld_type_i, ld_addr_i[OW-1:0]);
        ld_waddr = {ld_addr_i[ADDR_W-1:OW], OW'(0)};
        ld_idx   = '0;
        ld_match = 1'b0;
        m_be     = '0;
        m_data   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ld_idx = head_q + PW'(i);
            if ((CW'(i) < count_q) && (addr_q[ld_idx] == ld_waddr)) begin
                ld_match = 1'b1;
                m_be     = be_q[ld_idx];
                m_data   = data_q[ld_idx];
            end
        end
    end

    assign ld_cover   = ((m_be & ld_be) == ld_be);
    assign ld_hit_o   = ld_valid_i && ld_match && ld_cover;
    assign ld_stall_o = ld_valid_i && ld_match && !ld_cover;
    assign ld_data_o  = ld_hit_o ? m_data : '0;

    assign count_o     = count_q;
    assign empty_o     = (count_q == '0);
    assign full_o      = (count_q == CW'(DEPTH));
    assign st_ready_o  = !full_o;
    assign err_o       = err_q;
    assign mem_valid_o = !empty_o;
    assign mem_addr_o  = mem_valid_o ? addr_q[head_q] : '0;
    assign mem_data_o  = mem_valid_o ? data_q[head_q] : '0;
    assign mem_be_o    = mem_valid_o ? be_q[head_q]   : '0;

endmodule

// File: tb/tb_segre_store_buffer.sv
// Self-checking bench for segre_store_buffer: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_segre_store_buffer;

    localparam int unsigned DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        st_valid_i, st_ready_o;
    logic [31:0] st_addr_i, st_data_i;
    logic [1:0]  st_type_i;
    logic        ld_valid_i;
    logic [31:0] ld_addr_i;
    logic [1:0]  ld_type_i;
    logic        ld_hit_o, ld_stall_o;
    logic [31:0] ld_data_o;
    logic        mem_valid_o, mem_ready_i;
    logic [31:0] mem_addr_o, mem_data_o;
    logic [3:0]  mem_be_o;
    logic [2:0]  count_o;
    logic        empty_o, full_o, err_o;

    segre_store_buffer dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .st_valid_i(st_valid_i), .st_ready_o(st_ready_o), .st_addr_i(st_addr_i),
        .st_data_i(st_data_i), .st_type_i(st_type_i),
        .ld_valid_i(ld_valid_i), .ld_addr_i(ld_addr_i), .ld_type_i(ld_type_i),
        .ld_hit_o(ld_hit_o), .ld_stall_o(ld_stall_o), .ld_data_o(ld_data_o),
        .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_be_o(mem_be_o),
        .count_o(count_o), .empty_o(empty_o), .full_o(full_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } ent_t;

    ent_t q[$];
    logic err_exp;
    int   checks = 0;
    int   errors = 0;

    function automatic logic [3:0] req_be(input logic [1:0] t, input int off);
        if (t == 2'd0) return 4'(1 << off);
        if (t == 2'd1) return 4'(3 << off);
        return 4'hF;
    endfunction

    // Reference: what one clock edge does to the queue of pending stores.
    task automatic tick();
        int   off;
        bit   mis, pop, err_nxt;
        ent_t e;
        pop     = (q.size() > 0) && mem_ready_i;
        err_nxt = 1'b0;
        if (st_valid_i && q.size() < DEPTH) begin
            off = int'(st_addr_i % 4);
            mis = (st_type_i == 2'd1 && (off % 2) != 0) || (st_type_i >= 2'd2 && off != 0);
            if (mis) begin
                err_nxt = 1'b1;
            end else begin
                e.addr = st_addr_i - 32'(off);
                e.data = st_data_i << (8 * off);
                e.be   = req_be(st_type_i, off);
                if (q.size() >= 2 && q[q.size()-1].addr == e.addr) begin
                    ent_t y;
                    y = q[q.size()-1];
                    for (int b = 0; b < 4; b++)
                        if (e.be[b]) y.data[8*b +: 8] = e.data[8*b +: 8];
                    y.be = y.be | e.be;
                    q[q.size()-1] = y;
                end else begin
                    q.push_back(e);
                end
            end
        end
        if (pop) void'(q.pop_front());
        @(posedge clk_i);
        #1;
        err_exp = err_nxt;
    endtask

    task automatic idle_inputs();
        st_valid_i = 0; st_addr_i = 0; st_data_i = 0; st_type_i = 0;
        ld_valid_i = 0; ld_addr_i = 0; ld_type_i = 0; mem_ready_i = 0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] t);
        st_valid_i = 1; st_addr_i = a; st_data_i = d; st_type_i = t;
        tick();
        st_valid_i = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_i = 1; q.delete(); err_exp = 0;
        #1;
        checks++;
        if ({st_ready_o, mem_valid_o, empty_o, full_o, count_o, ld_hit_o, ld_stall_o, err_o} !== 10'b1_0_1_0_000_0_0_0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b mv=%b emp=%b full=%b cnt=%0d hit=%b stall=%b err=%b want 1 0 1 0 0 0 0 0",
                     st_ready_o, mem_valid_o, empty_o, full_o, count_o, ld_hit_o, ld_stall_o, err_o);
        end
        @(posedge clk_i); @(posedge clk_i); #1;
        rst_i = 0;
    endtask

    task automatic test_word_store();
        mem_ready_i = 1;
        store(32'h100, 32'hDEADBEEF, 2'd2);
        checks++;
        if ({mem_valid_o, mem_addr_o, mem_be_o, mem_data_o} !== {1'b1, 32'h100, 4'hF, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL word_store_head got v=%b a=%h be=%h d=%h want 1 00000100 f deadbeef",
                     mem_valid_o, mem_addr_o, mem_be_o, mem_data_o);
        end
        tick();
        checks++;
        if (empty_o !== 1'b1) begin errors++; $display("FAIL word_store_drain empty=%b want 1", empty_o); end
        mem_ready_i = 0;
    endtask

    task automatic test_coalesce();
        mem_ready_i = 0;
        store(32'h200, 32'h11223344, 2'd2);
        store(32'h104, 32'hAA, 2'd0);
        store(32'h105, 32'hBB, 2'd0);
        checks++;
        if (count_o !== 3'd2) begin errors++; $display("FAIL coalesce_count got %0d want 2", count_o); end
        ld_valid_i = 1; ld_addr_i = 32'h104; ld_type_i = 2'd1; #1;
        checks++;
        if ({ld_hit_o, ld_stall_o, ld_data_o} !== {2'b10, 32'h0000BBAA}) begin
            errors++; $display("FAIL coalesce_ld_half got hit=%b stall=%b d=%h want 1 0 0000bbaa", ld_hit_o, ld_stall_o, ld_data_o);
        end
        ld_type_i = 2'd2; #1;
        checks++;
        if ({ld_hit_o, ld_stall_o, ld_data_o} !== {2'b01, 32'h0}) begin
            errors++; $display("FAIL coalesce_ld_word got hit=%b stall=%b d=%h want 0 1 0", ld_hit_o, ld_stall_o, ld_data_o);
        end
        ld_valid_i = 0;
        mem_ready_i = 1;
        tick();
        checks++;
        if ({mem_addr_o, mem_be_o, mem_data_o} !== {32'h104, 4'b0011, 32'h0000BBAA}) begin
            errors++; $display("FAIL coalesce_youngest got a=%h be=%b d=%h want 00000104 0011 0000bbaa", mem_addr_o, mem_be_o, mem_data_o);
        end
        tick();
        mem_ready_i = 0;
    endtask

    task automatic test_full_wrap();
        logic [31:0] want;
        mem_ready_i = 0;
        for (int i = 0; i < 4; i++) store(32'h400 + 32'(i) * 32'h10, 32'(i + 1), 2'd2);
        checks++;
        if ({full_o, st_ready_o, count_o} !== {2'b10, 3'd4}) begin
            errors++; $display("FAIL full_flags got full=%b rdy=%b cnt=%0d want 1 0 4", full_o, st_ready_o, count_o);
        end
        st_valid_i = 1; st_addr_i = 32'h440; st_data_i = 32'h5; st_type_i = 2'd2;
        tick();
        checks++;
        if (count_o !== 3'd4) begin errors++; $display("FAIL full_held got cnt=%0d want 4", count_o); end
        mem_ready_i = 1;
        tick();
        mem_ready_i = 0;
        checks++;
        if ({full_o, st_ready_o, count_o} !== {2'b01, 3'd3}) begin
            errors++; $display("FAIL full_pulse got full=%b rdy=%b cnt=%0d want 0 1 3", full_o, st_ready_o, count_o);
        end
        tick();
        st_valid_i = 0;
        checks++;
        if (count_o !== 3'd4) begin errors++; $display("FAIL fifth_accept got cnt=%0d want 4", count_o); end
        mem_ready_i = 1;
        for (int k = 0; k < 4; k++) begin
            want = 32'h410 + 32'(k) * 32'h10;
            checks++;
            if (mem_addr_o !== want) begin errors++; $display("FAIL wrap_order[%0d] got %h want %h", k, mem_addr_o, want); end
            tick();
        end
        checks++;
        if (empty_o !== 1'b1) begin errors++; $display("FAIL wrap_empty got %b want 1", empty_o); end
        mem_ready_i = 0;
    endtask

    task automatic test_misaligned();
        logic [31:0] addrs [2];
        logic [1:0]  types [2];
        addrs[0] = 32'h101; types[0] = 2'd1;
        addrs[1] = 32'h102; types[1] = 2'd2;
        for (int k = 0; k < 2; k++) begin
            store(addrs[k], 32'h1234, types[k]);
            checks++;
            if ({err_o, count_o} !== {1'b1, 3'd0}) begin
                errors++; $display("FAIL misaligned[%0d] got err=%b cnt=%0d want 1 0", k, err_o, count_o);
            end
            tick();
            checks++;
            if (err_o !== 1'b0) begin errors++; $display("FAIL misaligned_pulse[%0d] got err=%b want 0", k, err_o); end
        end
    endtask

    task automatic test_head_no_coalesce();
        mem_ready_i = 0;
        store(32'h300, 32'h11, 2'd0);
        store(32'h301, 32'h22, 2'd0);
        checks++;
        if ({count_o, mem_addr_o, mem_be_o, mem_data_o} !== {3'd2, 32'h300, 4'h1, 32'h11}) begin
            errors++; $display("FAIL head_frozen got cnt=%0d a=%h be=%h d=%h want 2 00000300 1 00000011",
                               count_o, mem_addr_o, mem_be_o, mem_data_o);
        end
        ld_valid_i = 1; ld_addr_i = 32'h301; ld_type_i = 2'd0; #1;
        checks++;
        if ({ld_hit_o, ld_data_o} !== {1'b1, 32'h2200}) begin
            errors++; $display("FAIL young_byte_hit got hit=%b d=%h want 1 00002200", ld_hit_o, ld_data_o);
        end
        ld_addr_i = 32'h300; #1;
        checks++;
        if ({ld_hit_o, ld_stall_o} !== 2'b01) begin
            errors++; $display("FAIL young_shadow_stall got hit=%b stall=%b want 0 1", ld_hit_o, ld_stall_o);
        end
        ld_valid_i = 0;
    endtask

    task automatic test_async_reset();
        store(32'h500, 32'h77, 2'd0);
        checks++;
        if ({count_o, mem_valid_o} !== {3'd3, 1'b1}) begin
            errors++; $display("FAIL pre_reset got cnt=%0d mv=%b want 3 1", count_o, mem_valid_o);
        end
        mem_ready_i = 1;
        #2 rst_i = 1;
        #1;
        q.delete(); err_exp = 0;
        checks++;
        if ({mem_valid_o, count_o, empty_o} !== {1'b0, 3'd0, 1'b1}) begin
            errors++; $display("FAIL async_reset got mv=%b cnt=%0d emp=%b want 0 0 1", mem_valid_o, count_o, empty_o);
        end
        @(posedge clk_i); #1;
        rst_i = 0; mem_ready_i = 0;
        #1;
        checks++;
        if (count_o !== 3'd0) begin errors++; $display("FAIL post_reset got cnt=%0d want 0", count_o); end
    endtask

    task automatic test_random();
        logic [31:0] raw, exp_mem_addr, exp_mem_data, exp_ld_data;
        logic [3:0]  exp_mem_be, lbe;
        logic [1:0]  t;
        logic        exp_hit, exp_stall;
        int          lt;
        for (int c = 0; c < 800; c++) begin
            t           = 2'($urandom_range(0, 2));
            raw         = $urandom;
            st_valid_i  = ($urandom_range(0, 99) < 60);
            st_type_i   = t;
            st_addr_i   = 32'h800 + 32'($urandom_range(0, 2)) * 4 + 32'($urandom_range(0, 3));
            st_data_i   = (t == 2'd0) ? (raw & 32'hFF) : (t == 2'd1) ? (raw & 32'hFFFF) : raw;
            mem_ready_i = ($urandom_range(0, 99) < 35);
            lt          = $urandom_range(0, 2);
            ld_valid_i  = 1'($urandom_range(0, 1));
            ld_type_i   = 2'(lt);
            ld_addr_i   = 32'h800 + 32'($urandom_range(0, 3)) * 4 +
                          ((lt == 0) ? 32'($urandom_range(0, 3)) : (lt == 1) ? 32'($urandom_range(0, 1)) * 2 : 32'h0);
            #1;
            exp_hit = 0; exp_stall = 0; exp_ld_data = 0;
            lbe = req_be(ld_type_i, int'(ld_addr_i % 4));
            if (ld_valid_i) begin
                for (int i = q.size() - 1; i >= 0; i--) begin
                    if (q[i].addr == (ld_addr_i & ~32'h3)) begin
                        exp_hit     = ((q[i].be & lbe) == lbe);
                        exp_stall   = !exp_hit;
                        exp_ld_data = exp_hit ? q[i].data : 32'h0;
                        break;
                    end
                end
            end
            exp_mem_addr = (q.size() > 0) ? q[0].addr : 32'h0;
            exp_mem_data = (q.size() > 0) ? q[0].data : 32'h0;
            exp_mem_be   = (q.size() > 0) ? q[0].be   : 4'h0;
            checks++;
            if ({count_o, full_o, empty_o, st_ready_o} !== {3'(q.size()), q.size() == DEPTH, q.size() == 0, q.size() != DEPTH}) begin
                errors++; $display("FAIL rnd_occupancy c=%0d got cnt=%0d full=%b emp=%b rdy=%b want cnt=%0d", c, count_o, full_o, empty_o, st_ready_o, q.size());
            end
            checks++;
            if ({mem_valid_o, mem_addr_o, mem_be_o, mem_data_o} !== {q.size() > 0, exp_mem_addr, exp_mem_be, exp_mem_data}) begin
                errors++; $display("FAIL rnd_mem c=%0d got v=%b a=%h be=%h d=%h want a=%h be=%h d=%h", c, mem_valid_o, mem_addr_o, mem_be_o, mem_data_o, exp_mem_addr, exp_mem_be, exp_mem_data);
            end
            checks++;
            if ({ld_hit_o, ld_stall_o, ld_data_o} !== {exp_hit, exp_stall, exp_ld_data}) begin
                errors++; $display("FAIL rnd_load c=%0d got hit=%b stall=%b d=%h want %b %b %h", c, ld_hit_o, ld_stall_o, ld_data_o, exp_hit, exp_stall, exp_ld_data);
            end
            checks++;
            if (err_o !== err_exp) begin errors++; $display("FAIL rnd_err c=%0d got %b want %b", c, err_o, err_exp); end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_word_store();
        test_coalesce();
        test_full_wrap();
        test_misaligned();
        test_head_no_coalesce();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
